// File: rtl/fetch_sequencer_if.sv
// Sequencer <-> control-unit bundle: run request, IR fields, execute
// handshake, and the datapath control outputs driven by the sequencer.
interface fetch_sequencer_if #(
    parameter int SC_WIDTH = 4
);
    logic                       enable;
    logic [2:0]                 ir_opcode;
    logic                       ir_i;
    logic                       exec_done;
    logic [7:0]                 bus_sel;
    logic                       ar_load;
    logic                       ir_load;
    logic                       pc_incr;
    logic                       mem_read;
    logic [SC_WIDTH-1:0]        sc;
    logic [(1<<SC_WIDTH)-1:0]   t_state;
    logic [7:0]                 d;
    logic                       i_flag;
    logic                       exec_start;
    logic                       busy;
    logic                       timeout;

    // Sequencer side
    modport master (
        input  enable, ir_opcode, ir_i, exec_done,
        output bus_sel, ar_load, ir_load, pc_incr, mem_read,
               sc, t_state, d, i_flag, exec_start, busy, timeout
    );

    // Control unit / datapath side
    modport slave (
        output enable, ir_opcode, ir_i, exec_done,
        input  bus_sel, ar_load, ir_load, pc_incr, mem_read,
               sc, t_state, d, i_flag, exec_start, busy, timeout
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Timing / fetch-decode sequencer: runs SC and its T-state decode, drives the
// fetch, decode and indirect micro-ops, then hands off to the execute unit.
module fetch_sequencer #(
    parameter int SC_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.master bus
);
    localparam int NT = 1 << SC_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [SC_WIDTH-1:0] SC_T1  = SC_WIDTH'(1);
    localparam logic [SC_WIDTH-1:0] SC_T2  = SC_WIDTH'(2);
    localparam logic [SC_WIDTH-1:0] SC_T3  = SC_WIDTH'(3);
    localparam logic [SC_WIDTH-1:0] SC_T4  = SC_WIDTH'(4);
    localparam logic [SC_WIDTH-1:0] SC_MAX = '1;
    localparam logic [NT-1:0]       T_ONE  = NT'(1);

    logic [0:0]          r_state;
    logic [SC_WIDTH-1:0] r_sc;
    logic [7:0]          r_d;
    logic                r_i_flag;
    logic                r_started;   // exec_start already issued this instruction
    logic                r_timeout;

    logic                w_busy;
    logic                w_exec_start;
    logic                w_exec_phase;
    logic                w_accept;
    logic [SC_WIDTH-1:0] w_sc_next;

    assign w_busy       = (r_state == S_RUN);
    // Register-reference instructions need no T3 operand work, so they start a cycle early.
    assign w_exec_start = w_busy && (r_sc == (r_d[7] ? SC_T3 : SC_T4));
    assign w_exec_phase = w_exec_start || r_started;
    assign w_accept     = w_exec_phase && bus.exec_done;
    assign w_sc_next    = (r_sc == SC_MAX) ? SC_MAX : r_sc + SC_T1;

    // Sequence counter, run state, latched decode and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sc      <= '0;
            r_d       <= '0;
            r_i_flag  <= 1'b0;
            r_started <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!w_busy) begin
            r_sc      <= '0;
            r_started <= 1'b0;
            if (bus.enable) r_state <= S_RUN;
        end else if (w_accept) begin
            // Instruction boundary: enable decides between back-to-back fetch and idle
            r_sc      <= '0;
            r_started <= 1'b0;
            r_state   <= bus.enable ? S_RUN : S_IDLE;
        end else begin
            r_sc <= w_sc_next;
            if (w_exec_start) r_started <= 1'b1;
            if (r_sc == SC_T2) begin
                r_d      <= 8'h01 << bus.ir_opcode;
                r_i_flag <= bus.ir_i;
            end
            if (w_sc_next == SC_MAX) r_timeout <= 1'b1;
        end
    end

    // Fetch/decode/indirect micro-ops; the execute unit owns the bus once exec_start fires
    always_comb begin
        bus.bus_sel  = 8'h01;
        bus.ar_load  = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_incr  = 1'b0;
        bus.mem_read = 1'b0;
        if (w_busy && !w_exec_phase) begin
            case (r_sc)
                '0: begin
                    bus.bus_sel = 8'h04;
                    bus.ar_load = 1'b1;
                end
                SC_T1: begin
                    bus.bus_sel  = 8'h80;
                    bus.mem_read = 1'b1;
                    bus.ir_load  = 1'b1;
                    bus.pc_incr  = 1'b1;
                end
                SC_T2: begin
                    bus.bus_sel = 8'h20;
                    bus.ar_load = 1'b1;
                end
                SC_T3: begin
                    if (!r_d[7] && r_i_flag) begin
                        bus.bus_sel  = 8'h80;
                        bus.mem_read = 1'b1;
                        bus.ar_load  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sc         = r_sc;
    assign bus.t_state    = w_busy ? (T_ONE << r_sc) : '0;
    assign bus.d          = r_d;
    assign bus.i_flag     = r_i_flag;
    assign bus.exec_start = w_exec_start;
    assign bus.busy       = w_busy;
    assign bus.timeout    = r_timeout;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Timing and fetch/decode sequencer for the basic computer's control unit. It runs the sequence counter SC and its T0..T15 timing decode. It drives the fetch, decode and indirect micro-operations. Its primary output is the 8-bit one-hot bus-source select, consumed directly by the 8×3 bus-select encoder. It then hands execution to the execute unit through a start/done handshake.

Parameters:
SC_WIDTH, 4, sequence counter width; the timing decode is 2**SC_WIDTH wide.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
enable  input  1  run request (S flag); sampled only at instruction boundaries.
ir_opcode  input  3  IR[14:12], valid from T2.
ir_i  input  1  IR[15] indirect bit, valid from T2.
exec_done  input  1  execute unit finished; request SC clear.
bus_sel  output  8  one-hot bus source: bit0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
ar_load  output  1  load AR from bus.
ir_load  output  1  load IR from bus.
pc_incr  output  1  increment PC.
mem_read  output  1  memory read strobe.
sc  output  SC_WIDTH  current sequence count.
t_state  output  2**SC_WIDTH  one-hot decode of sc; all-zero when idle.
d  output  8  registered one-hot opcode decode D0..D7.
i_flag  output  1  registered indirect bit.
exec_start  output  1  one-cycle pulse handing control to the execute unit.
busy  output  1  high while an instruction is in progress.
timeout  output  1  sticky: SC saturated without exec_done.

Behaviour:
- Reset (async, rst_n=0), effective immediately regardless of clk:
  - idle; sc=0; d=0; i_flag=0; timeout=0.
  - bus_sel=8'h01; all strobes, exec_start and busy low; t_state=0.
- Idle:
  - Stays idle with sc=0 while enable=0.
  - enable=1 on an edge → next cycle is T0 with busy=1.
- Outputs are combinational from registered state; bus_sel is always exactly one-hot.
- T0: bus_sel=8'h04 (PC); ar_load=1.
- T1: bus_sel=8'h80 (memory); mem_read=1; ir_load=1; pc_incr=1.
- T2:
  - bus_sel=8'h20 (IR); ar_load=1.
  - At the T2 edge, d <= onehot(ir_opcode) and i_flag <= ir_i.
- T3, memory-reference (d[7]=0):
  - If i_flag=1: bus_sel=8'h80, mem_read=1, ar_load=1.
  - Otherwise bus_sel=8'h01 with no strobes.
- exec_start timing:
  - d[7]=1: exec_start=1 during T3.
  - d[7]=0: exec_start=1 during T4.
  - Exactly one pulse per instruction.
- Execute phase:
  - From the exec_start cycle onward, bus_sel=8'h01 and the sequencer drives no strobes; the execute unit owns the datapath.
  - sc increments every cycle.
- exec_done handling:
  - Accepted only in or after the exec_start cycle; ignored earlier in the instruction.
  - exec_done may be asserted in the same cycle as exec_start (single-cycle execute).
  - On acceptance, sc <= 0 at the next edge.
  - If enable=1, the next cycle is T0 (back-to-back fetch, no bubble).
  - If enable=0, the sequencer goes idle.
- enable is sampled only at the boundary (idle, or the cycle exec_done is accepted). Deasserting it mid-instruction lets the current instruction complete.
- Saturation: if sc reaches 2**SC_WIDTH-1 with no exec_done, sc holds there and timeout sets. timeout clears only on reset. exec_done still returns to T0/idle.
- d and i_flag hold until the next T2; they are valid to the execute unit from T3 until the boundary.

Test Plan:
- Reset → bus_sel=8'h01, sc=0, busy=0. Release with enable=1 → T0 at cycle 1: bus_sel=8'h04, ar_load=1.
- Register-ref: ir_opcode=3'b111, ir_i=0, exec_done=1 in T3.
  - bus_sel sequence 8'h04, 8'h80, 8'h20, 8'h01.
  - exec_start in T3; d=8'h80; next cycle T0 (4-cycle instruction).
- Indirect memory-ref: ir_opcode=3'b010, ir_i=1, exec_done at sc=6.
  - T3: bus_sel=8'h80, ar_load=1, mem_read=1.
  - exec_start at T4 only; sc=0 after sc=6.
- Direct memory-ref: ir_opcode=3'b001, ir_i=0 → T3 bus_sel=8'h01 with no strobes. exec_done asserted at T1 is ignored (sc continues to 2).
- exec_done never asserted → sc saturates at 15 and timeout=1. A later exec_done returns to T0 while timeout stays 1. rst_n pulse clears timeout.
- Boundary and mid-operation cases:
  - enable dropped during T1: the instruction completes and the sequencer goes idle after exec_done (busy=0, t_state=0).
  - rst_n asserted mid-T2 with no clock edge: outputs reach reset values immediately.
